pid_loop_sequencer: RTL and testbench
=====================================

Name: pid_loop_sequencer

Overview:
- Control-loop initiator that drives the PI arithmetic pipeline (setpoint/actual/integral in; integral and output back).
- Each iteration:
  - requests an ADC sample;
  - presents it to the pipeline as the actual value;
  - waits out the pipeline latency;
  - captures the updated integral and the output;
  - saturates the output to DAC range and writes it to the DAC.
- Sits between the ADC/DAC handshake masters and the arithmetic pipeline.
- Owns the persistent integral state.

Parameters:
- INPUT_WIDTH, 18, width of ADC sample / actual / setpoint.
- OUTPUT_WIDTH, 32, width of integral and pipeline output.
- DAC_WIDTH, 20, signed DAC word width; must be ≤ OUTPUT_WIDTH.
- PIPE_LATENCY, 4, cycles from actual presented to output valid; must be ≥ INTEG_TAP+1.
- INTEG_TAP, 2, cycles from actual presented to updated integral valid.

Ports:
- clk  in  1  system clock
- rst_L  in  1  synchronous active-low reset
- i_run  in  1  level; high = iterate continuously
- i_clear_integral  in  1  one-cycle pulse; zero stored integral
- o_adc_arm  out  1  ADC request, held until finished
- i_adc_finished  in  1  ADC conversion done; data valid same cycle
- i_adc_data  in  INPUT_WIDTH  signed ADC sample
- o_actual  out  INPUT_WIDTH  signed, to pipeline actual input
- o_integral  out  OUTPUT_WIDTH  signed, to pipeline integral input
- i_pipe_integral  in  OUTPUT_WIDTH  signed, pipeline updated integral
- i_pipe_out  in  OUTPUT_WIDTH  signed, pipeline output
- o_dac_arm  out  1  DAC write request, held until finished
- o_dac_data  out  DAC_WIDTH  signed saturated output
- i_dac_finished  in  1  DAC write complete
- o_busy  out  1  high in any state but IDLE
- o_saturated  out  1  last written value was clamped
- o_iter_count  out  32  completed iterations, wraps 2^32-1→0

Behaviour:
- Reset (rst_L low at clk edge) is synchronous, active-low, single clock. All of the following take effect at the next edge, even mid-handshake:
  - state=IDLE;
  - o_adc_arm, o_dac_arm, o_busy, o_saturated = 0;
  - o_actual, o_integral, o_dac_data, o_iter_count = 0;
  - clear-pending flag and latency counter = 0.
- FSM states:
  - IDLE: o_busy=0. If i_run=1, go to ADC_REQ.
  - ADC_REQ: assert o_arm-level o_adc_arm=1, go to ADC_WAIT.
  - ADC_WAIT: hold o_adc_arm=1. When i_adc_finished=1: latch o_actual<=i_adc_data, drop o_adc_arm, clear counter, go to PIPE_WAIT.
  - PIPE_WAIT: counter increments each cycle. At counter==INTEG_TAP-1, latch the next integral (see clear rule). At counter==PIPE_LATENCY-1, latch the saturated i_pipe_out into o_dac_data, update o_saturated, go to DAC_REQ.
  - DAC_REQ: o_dac_arm=1, go to DAC_WAIT.
  - DAC_WAIT: hold o_dac_arm=1. When i_dac_finished=1: drop o_dac_arm, o_iter_count++. Go to ADC_REQ if i_run=1, else IDLE.
- o_actual and o_integral stay stable from ADC capture until the next ADC capture. The pipeline is free-running, so its result depends only on these held values.
- Arm/finished rules:
  - Arm rises only from a REQ state.
  - Finished is ignored outside its WAIT state.
  - Finished asserted in the same cycle arm rises is accepted on the next cycle (WAIT samples it).
- i_run deassert mid-iteration: the current iteration completes, including the DAC write, then IDLE. No handshake is abandoned.
- Integral clear:
  - A pulse in IDLE, ADC_REQ or ADC_WAIT zeroes o_integral next cycle.
  - A pulse in any other state sets clear-pending.
  - At the INTEG_TAP capture, o_integral <= 0 if clear-pending (or a pulse arrives that cycle), else i_pipe_integral; pending is then cleared.
  - Clear wins over capture.
- Saturation:
  - MAX = 2^(DAC_WIDTH-1)-1, MIN = -2^(DAC_WIDTH-1).
  - i_pipe_out > MAX → MAX; < MIN → MIN; else truncate to DAC_WIDTH bits.
  - o_saturated = 1 iff clamped.
  - Signed comparisons throughout.
- Minimum iteration with zero-wait peripherals: 1+1+PIPE_LATENCY+1+1 = 8 cycles.

Decomposition:
- Shared package pid_pkg:
  - state encoding enum;
  - default widths and latencies (INPUT_WIDTH, OUTPUT_WIDTH, PIPE_LATENCY, INTEG_TAP) for reuse by the pipeline and the top level.
- One natural sub-module, sat_clamp: parameterised signed OUTPUT_WIDTH→DAC_WIDTH clamp with a saturated flag. Purely combinational, instantiated once.

Test Plan:
- Reset mid ADC_WAIT (arm high), rst_L=0 for one edge → next cycle arm=0, state IDLE, o_integral=0, o_iter_count=0.
- i_run=1, ADC returns 100 on the 3rd wait cycle, pipe model out=5000 at latency 4, DAC finishes immediately → o_dac_data=5000, o_saturated=0, o_iter_count=1, o_actual=100 held throughout.
- Pipe out = 0x0010_0000 (1048576) with DAC_WIDTH=20 → o_dac_data=524287, o_saturated=1. Pipe out = -2000000 → o_dac_data=-524288, o_saturated=1.
- Integral carries across iterations: pipe integral returns 42, then 42+err. Next iteration presents o_integral=42. i_clear_integral pulsed during PIPE_WAIT before the tap → captured integral=0.
- i_run dropped during PIPE_WAIT → DAC write still occurs, o_iter_count increments, then IDLE with o_busy=0 and no new o_adc_arm.
- Zero-wait ADC/DAC, i_run held → an iteration completes every 8 cycles. Preload o_iter_count path to 0xFFFF_FFFF → next completion gives 0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the PI control loop: sequencer state encoding and
// default datapath widths / pipeline timing used by the sequencer and pipeline.
package pid_pkg;

   localparam int unsigned INPUT_WIDTH  = 18;
   localparam int unsigned OUTPUT_WIDTH = 32;
   localparam int unsigned PIPE_LATENCY = 4;
   localparam int unsigned INTEG_TAP    = 2;

   typedef enum logic [2:0] {
      IDLE,
      ADC_REQ,
      ADC_WAIT,
      PIPE_WAIT,
      DAC_REQ,
      DAC_WAIT
   } state_t;

endpackage

// File: rtl/pid_loop_sequencer_sat_clamp.sv
// Signed narrowing clamp: limits a wide signed value to the range of a
// narrower signed word and flags when limiting occurred.
module sat_clamp #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 20
) (
   input  logic [IN_WIDTH-1:0]  value,
   output logic [OUT_WIDTH-1:0] clamped,
   output logic                 saturated
);

   // Range limits of the narrow word, sign-extended to the input width.
   localparam logic [IN_WIDTH-1:0] MAX_V = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [IN_WIDTH-1:0] MIN_V = ~MAX_V;

   always_comb begin
      clamped   = value[OUT_WIDTH-1:0];
      saturated = 1'b0;
      if ($signed(value) > $signed(MAX_V)) begin
         clamped   = MAX_V[OUT_WIDTH-1:0];
         saturated = 1'b1;
      end else if ($signed(value) < $signed(MIN_V)) begin
         clamped   = MIN_V[OUT_WIDTH-1:0];
         saturated = 1'b1;
      end
   end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Control-loop initiator for the PI pipeline: ADC sample -> pipeline -> DAC,
// owning the persistent integral and the completed-iteration counter.
module pid_loop_sequencer #(
   parameter int unsigned INPUT_WIDTH  = pid_pkg::INPUT_WIDTH,
   parameter int unsigned OUTPUT_WIDTH = pid_pkg::OUTPUT_WIDTH,
   parameter int unsigned DAC_WIDTH    = 20,
   parameter int unsigned PIPE_LATENCY = pid_pkg::PIPE_LATENCY,
   parameter int unsigned INTEG_TAP    = pid_pkg::INTEG_TAP
) (
   input  logic                    clk,
   input  logic                    rst_L,
   input  logic                    i_run,
   input  logic                    i_clear_integral,
   output logic                    o_adc_arm,
   input  logic                    i_adc_finished,
   input  logic [INPUT_WIDTH-1:0]  i_adc_data,
   output logic [INPUT_WIDTH-1:0]  o_actual,
   output logic [OUTPUT_WIDTH-1:0] o_integral,
   input  logic [OUTPUT_WIDTH-1:0] i_pipe_integral,
   input  logic [OUTPUT_WIDTH-1:0] i_pipe_out,
   output logic                    o_dac_arm,
   output logic [DAC_WIDTH-1:0]    o_dac_data,
   input  logic                    i_dac_finished,
   output logic                    o_busy,
   output logic                    o_saturated,
   output logic [31:0]             o_iter_count
);

   import pid_pkg::*;

   localparam int unsigned CNT_W = $clog2(PIPE_LATENCY) + 1;
   localparam logic [CNT_W-1:0] TAP_CNT  = CNT_W'(INTEG_TAP - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIPE_LATENCY - 1);

   state_t state, state_nxt;

   logic [CNT_W-1:0]        lat_cnt;
   logic                    cap_actual;
   logic                    cap_integral;
   logic                    cap_out;
   logic                    iter_done;
   logic                    early_clear;
   logic                    clear_pending;
   logic [INPUT_WIDTH-1:0]  actual;
   logic [OUTPUT_WIDTH-1:0] integral;
   logic [DAC_WIDTH-1:0]    dac_data;
   logic                    saturated;
   logic [31:0]             iter_count;
   logic [DAC_WIDTH-1:0]    clamp_value;
   logic                    clamp_sat;

   sat_clamp #(
      .IN_WIDTH  (OUTPUT_WIDTH),
      .OUT_WIDTH (DAC_WIDTH)
   ) u_clamp (
      .value     (i_pipe_out),
      .clamped   (clamp_value),
      .saturated (clamp_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      o_adc_arm    = 1'b0;
      o_dac_arm    = 1'b0;
      o_busy       = 1'b1;
      cap_actual   = 1'b0;
      cap_integral = 1'b0;
      cap_out      = 1'b0;
      iter_done    = 1'b0;
      early_clear  = 1'b0;
      case (state)
         IDLE: begin
            o_busy      = 1'b0;
            early_clear = i_clear_integral;
            if (i_run) begin
               state_nxt = ADC_REQ;
            end
         end
         ADC_REQ: begin
            o_adc_arm   = 1'b1;
            early_clear = i_clear_integral;
            state_nxt   = ADC_WAIT;
         end
         ADC_WAIT: begin
            o_adc_arm   = 1'b1;
            early_clear = i_clear_integral;
            if (i_adc_finished) begin
               cap_actual = 1'b1;
               state_nxt  = PIPE_WAIT;
            end
         end
         PIPE_WAIT: begin
            if (lat_cnt == TAP_CNT) begin
               cap_integral = 1'b1;
            end
            if (lat_cnt == LAST_CNT) begin
               cap_out   = 1'b1;
               state_nxt = DAC_REQ;
            end
         end
         DAC_REQ: begin
            o_dac_arm = 1'b1;
            state_nxt = DAC_WAIT;
         end
         DAC_WAIT: begin
            o_dac_arm = 1'b1;
            if (i_dac_finished) begin
               iter_done = 1'b1;
               state_nxt = i_run ? ADC_REQ : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         lat_cnt       <= '0;
         actual        <= '0;
         integral      <= '0;
         clear_pending <= 1'b0;
         dac_data      <= '0;
         saturated     <= 1'b0;
         iter_count    <= '0;
      end else begin
         if (cap_actual) begin
            actual  <= i_adc_data;
            lat_cnt <= '0;
         end else if (state == PIPE_WAIT) begin
            lat_cnt <= lat_cnt + 1'b1;
         end

         // A clear arriving after the pipeline has consumed the integral is
         // deferred to the next tap so the in-flight update cannot undo it.
         if (early_clear) begin
            integral <= '0;
         end else if (cap_integral) begin
            integral      <= (clear_pending || i_clear_integral) ? '0 : i_pipe_integral;
            clear_pending <= 1'b0;
         end else if (i_clear_integral) begin
            clear_pending <= 1'b1;
         end

         if (cap_out) begin
            dac_data  <= clamp_value;
            saturated <= clamp_sat;
         end

         if (iter_done) begin
            iter_count <= iter_count + 32'd1;
         end
      end
   end

   assign o_actual     = actual;
   assign o_integral   = integral;
   assign o_dac_data   = dac_data;
   assign o_saturated  = saturated;
   assign o_iter_count = iter_count;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer with ADC/DAC responders and a
// free-running PI pipeline model (integral = I + err, out = I + 5*err).
module tb_pid_loop_sequencer;

   localparam longint SETPOINT = 1000;
   localparam longint DAC_MAX  = 524287;
   localparam longint DAC_MIN  = -524288;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        i_run;
   logic        i_clear_integral;
   logic        o_adc_arm;
   logic        i_adc_finished = 1'b0;
   logic [17:0] i_adc_data = '0;
   logic [17:0] o_actual;
   logic [31:0] o_integral;
   logic [31:0] i_pipe_integral;
   logic [31:0] i_pipe_out;
   logic        o_dac_arm;
   logic [19:0] o_dac_data;
   logic        i_dac_finished = 1'b0;
   logic        o_busy;
   logic        o_saturated;
   logic [31:0] o_iter_count;

   pid_loop_sequencer #(
      .INPUT_WIDTH  (18),
      .OUTPUT_WIDTH (32),
      .DAC_WIDTH    (20),
      .PIPE_LATENCY (4),
      .INTEG_TAP    (2)
   ) dut (
      .clk              (clk),
      .rst_L            (rst_L),
      .i_run            (i_run),
      .i_clear_integral (i_clear_integral),
      .o_adc_arm        (o_adc_arm),
      .i_adc_finished   (i_adc_finished),
      .i_adc_data       (i_adc_data),
      .o_actual         (o_actual),
      .o_integral       (o_integral),
      .i_pipe_integral  (i_pipe_integral),
      .i_pipe_out       (i_pipe_out),
      .o_dac_arm        (o_dac_arm),
      .o_dac_data       (o_dac_data),
      .i_dac_finished   (i_dac_finished),
      .o_busy           (o_busy),
      .o_saturated      (o_saturated),
      .o_iter_count     (o_iter_count)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   longint      m_integ;
   logic [31:0] m_count;

   int          adc_dly = 0;
   int          dac_dly = 0;
   int          adc_cnt = 0;
   int          dac_cnt = 0;
   logic [17:0] adc_value = '0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pipeline model: stage-0 arithmetic on the held inputs, integral after one
   // register, output after three.
   logic signed [31:0] act_ext, err_w, p_int0, p_out0, int_d;
   logic [31:0]        out_q [3];

   always_comb begin
      act_ext = {{14{o_actual[17]}}, o_actual};
      err_w   = 32'sd1000 - act_ext;
      p_int0  = $signed(o_integral) + err_w;
      p_out0  = ovr_en ? $signed(ovr_val) : $signed(o_integral) + 32'sd5 * err_w;
   end

   always @(posedge clk) begin
      int_d    <= p_int0;
      out_q[0] <= p_out0;
      out_q[1] <= out_q[0];
      out_q[2] <= out_q[1];
   end

   assign i_pipe_integral = int_d;
   assign i_pipe_out      = out_q[2];

   // ADC responder: finishes after adc_dly armed cycles, holds until arm drops.
   always @(negedge clk) begin
      if (o_adc_arm) begin
         if (adc_cnt >= adc_dly) begin
            i_adc_finished = 1'b1;
            i_adc_data     = adc_value;
         end else begin
            adc_cnt++;
            i_adc_data = 18'($urandom);
         end
      end else begin
         i_adc_finished = 1'b0;
         adc_cnt        = 0;
      end
   end

   always @(negedge clk) begin
      if (o_dac_arm) begin
         if (dac_cnt >= dac_dly) begin
            i_dac_finished = 1'b1;
         end else begin
            dac_cnt++;
         end
      end else begin
         i_dac_finished = 1'b0;
         dac_cnt        = 0;
      end
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clampv(input longint v);
      if (v > DAC_MAX) return DAC_MAX;
      if (v < DAC_MIN) return DAC_MIN;
      return v;
   endfunction

   // One single-shot iteration; clr_mode 0 none, 1 pulse in PIPE_WAIT before
   // the tap, 2 pulse while idle before starting.
   task automatic do_iter(input string tag, input longint adc_val, input int a_dly, input int d_dly,
                          input bit use_ovr, input longint ovr, input int clr_mode);
      longint pre, err, raw, exp_int;
      bit     ok;
      adc_value = 18'(adc_val);
      adc_dly   = a_dly;
      dac_dly   = d_dly;
      ovr_en    = use_ovr;
      ovr_val   = 32'(ovr);
      if (clr_mode == 2) begin
         i_clear_integral = 1'b1;
         @(negedge clk);
         i_clear_integral = 1'b0;
         m_integ = 0;
         check({tag, "_idle_clr"}, $signed(o_integral), 0);
      end
      pre     = m_integ;
      err     = SETPOINT - adc_val;
      exp_int = (clr_mode == 1) ? 0 : pre + err;
      raw     = use_ovr ? ovr : pre + 5 * err;

      i_run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_adc_arm) begin ok = 1'b1; break; end
      end
      if (!ok) check({tag, "_tmo_adc_arm"}, o_adc_arm, 1);
      ok = 1'b0;
      for (int i = 0; i < a_dly + 10; i++) begin
         @(negedge clk);
         if (!o_adc_arm) begin ok = 1'b1; break; end
      end
      if (!ok) check({tag, "_tmo_adc_done"}, o_adc_arm, 0);

      i_run = 1'b0;
      if (clr_mode == 1) i_clear_integral = 1'b1;
      check({tag, "_actual"}, $signed(o_actual), adc_val);
      check({tag, "_integ_in"}, $signed(o_integral), pre);
      @(negedge clk);
      i_clear_integral = 1'b0;

      ok = 1'b0;
      for (int i = 0; i < d_dly + 20; i++) begin
         if (o_iter_count != m_count) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      m_count = m_count + 32'd1;
      check({tag, "_count"}, o_iter_count, m_count);
      check({tag, "_dac"}, $signed(o_dac_data), clampv(raw));
      check({tag, "_sat"}, o_saturated, (clampv(raw) != raw));
      check({tag, "_integ"}, $signed(o_integral), exp_int);
      check({tag, "_actual_hold"}, $signed(o_actual), adc_val);
      m_integ = exp_int;
      @(negedge clk);
      check({tag, "_idle_busy"}, o_busy, 0);
      check({tag, "_idle_arm"}, o_adc_arm, 0);
   endtask

   initial begin
      logic [17:0] r_adc;
      logic [31:0] r_ovr;
      logic [31:0] last;
      int          stamps [4];
      int          clr;
      bit          ok;

      rst_L            = 1'b0;
      i_run            = 1'b0;
      i_clear_integral = 1'b0;
      m_integ          = 0;
      m_count          = '0;
      repeat (3) @(negedge clk);
      check("rst_adc_arm", o_adc_arm, 0);
      check("rst_dac_arm", o_dac_arm, 0);
      check("rst_busy", o_busy, 0);
      check("rst_count", o_iter_count, 0);
      check("rst_dac", o_dac_data, 0);
      rst_L = 1'b1;
      @(negedge clk);

      do_iter("basic", 100, 3, 0, 1'b1, 5000, 0);
      do_iter("sat_hi", 0, 0, 1, 1'b1, 1048576, 0);
      do_iter("sat_lo", 0, 1, 0, 1'b1, -2000000, 0);
      do_iter("edge_max", 5, 0, 0, 1'b1, 524287, 0);
      do_iter("edge_min", 5, 0, 0, 1'b1, -524288, 0);
      do_iter("over_max", 5, 0, 0, 1'b1, 524288, 0);
      do_iter("carry1", 958, 0, 0, 1'b0, 0, 2);
      do_iter("carry2", 500, 1, 1, 1'b0, 0, 0);
      do_iter("clr_pipe", 700, 0, 2, 1'b0, 0, 1);

      // Continuous zero-wait run: one completion every 8 cycles.
      adc_value = 18'd900;
      adc_dly   = 0;
      dac_dly   = 0;
      ovr_en    = 1'b0;
      last      = o_iter_count;
      i_run     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_iter_count != last) begin ok = 1'b1; break; end
         end
         if (!ok) check("cont_tmo", o_iter_count, last + 32'd1);
         stamps[k] = cyc;
         last      = o_iter_count;
      end
      i_run = 1'b0;
      for (int k = 1; k < 4; k++) check("cont_gap", stamps[k] - stamps[k-1], 8);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!o_busy) begin ok = 1'b1; break; end
      end
      if (!ok) check("cont_tmo_idle", o_busy, 0);
      m_count = m_count + 32'd5;
      check("cont_count", o_iter_count, m_count);
      check("cont_dac", $signed(o_dac_data), clampv(m_integ + 400 + 500));
      m_integ = m_integ + 500;
      check("cont_integ", $signed(o_integral), m_integ);

      // Reset while waiting on the ADC, after a saturating write.
      do_iter("pre_rst", 0, 0, 0, 1'b1, 3000000, 0);
      adc_dly = 1000;
      i_run   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_adc_arm) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      check("mid_adc_arm", o_adc_arm, 1);
      rst_L = 1'b0;
      @(negedge clk);
      rst_L = 1'b1;
      i_run = 1'b0;
      check("mrst_adc_arm", o_adc_arm, 0);
      check("mrst_busy", o_busy, 0);
      check("mrst_integ", o_integral, 0);
      check("mrst_count", o_iter_count, 0);
      check("mrst_actual", o_actual, 0);
      check("mrst_dac", o_dac_data, 0);
      check("mrst_sat", o_saturated, 0);
      m_integ = 0;
      m_count = '0;
      @(negedge clk);
      check("mrst_no_rearm", o_adc_arm, 0);

      // Counter wrap from all-ones.
      force dut.iter_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.iter_count;
      m_count = 32'hFFFF_FFFF;
      @(negedge clk);
      check("wrap_preload", o_iter_count, m_count);
      do_iter("wrap", 1200, 0, 0, 1'b0, 0, 0);

      for (int k = 0; k < 12; k++) begin
         r_adc = 18'($urandom);
         r_ovr = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 1200000)) - 32'd600000;
         clr   = ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 4) == 0) ? 2 : 0);
         do_iter("rand", longint'($signed(r_adc)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), longint'($signed(r_ovr)), clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

endmodule
